alu_mul_collect: RTL and testbench
==================================

# alu_mul_collect

Downstream companion of the sequential multiplier in the ALU. It reassembles the multiplier's two-beat product stream into one full-width result:

- low half on the cycle before `valid`;
- high half on the `valid` cycle.

It derives zero, sign and (optionally) overflow flags from the assembled result. Results are buffered in a small FIFO behind a valid/ready handshake, and `busy` back-pressures the operand issue logic so no product is ever lost.

## Interface
- `data_wl`, 16, width of one product half
- `depth`, 2, result FIFO entries (power of two, ≥2)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `ld_in`  in  1  same pulse that loads the multiplier; marks a product in flight
- `signd`  in  1  signed-mode select, same signal fed to the multiplier
- `p_in`  in  data_wl  multiplier product port
- `valid_in`  in  1  multiplier valid (high-half beat)
- `busy`  out  1  upstream must not assert `ld_in` while high
- `res_out`  out  2*data_wl  assembled product, FIFO head
- `res_valid`  out  1  FIFO non-empty
- `res_ready`  in  1  consumer accepts head
- `res_z`  out  1  head result == 0
- `res_s`  out  1  head `signd` & head result MSB
- `res_ovf`  out  1  head result does not fit in data_wl (see Configuration)
- `ovr`  out  1  sticky: a product was dropped

## Operation
- `lo_reg` captures `p_in` on every cycle where `valid_in` = 0.
- On `valid_in` = 1 the entry {`p_in`, `lo_reg`} is formed together with flags (z, s, ovf) and the `signd` value sampled that cycle.
- FSM `inflight_st`:
  - IDLE → WAIT on `ld_in`.
  - WAIT → IDLE on `valid_in`.
  - `ld_in` in WAIT is ignored; the multiplier is single-issue.
  - `valid_in` in IDLE is still captured (stray product), not an error.
- Credit: `busy` = (count + (state==WAIT)) ≥ depth. It is computed from registers only, with no combinational path from `res_ready`.
- Write: occurs when `valid_in` and (count < depth or pop this cycle).
- Drop: when the FIFO is full and there is no pop, the entry is dropped and `ovr` is set. `ovr` clears only on reset.
- Pop: `res_valid` & `res_ready`. Head advances and count decrements.
  - Simultaneous push and pop leaves count unchanged.
  - Push to an empty FIFO with `res_ready` = 1 is not bypassed; the entry appears next cycle.
- Pointers wrap modulo depth; count has log2(depth)+1 bits.
- Flags are stored per entry, not recomputed at the head.

## Timing
- Reset values:
  - `busy`=0, `res_valid`=0, `res_out`=0, `res_z`=0, `res_s`=0, `res_ovf`=0, `ovr`=0.
  - FSM in IDLE, `lo_reg`=0, pointers and count = 0.
- Reset mid-operation discards in-flight state and all FIFO entries. It takes effect in the same clock edge as sampled.
- Latency: `valid_in` at cycle N → `res_valid` and data at N+1 (empty FIFO).
- `busy` rises the cycle after the `ld_in` that consumes the last credit. `ld_in` and `busy` in the same cycle is a protocol violation: it is ignored and not counted.
- Outputs are stable while `res_valid` & !`res_ready`.

## Configuration
- `ALU_MUL_COLLECT_OVF_EN` defined:
  - unsigned entries: `res_ovf` = (high half ≠ 0);
  - signed entries: `res_ovf` = (high half ≠ replication of low-half MSB).
  - The flag is stored per entry.
- Undefined: `res_ovf` tied 0 and the per-entry flag storage is removed.

## Structure
- Shared ALU package holds:
  - `data_wl` default;
  - FSM state constants IDLE/WAIT (one-hot, 2 bits);
  - the FIFO entry field widths (result, z, s, ovf).
- One sub-module: `alu_res_fifo`, a parameterised synchronous FIFO (width, depth) with push/pop, full/empty and count outputs. The assembly, flag logic and credit FSM stay in `alu_mul_collect`.

## Test plan
- Unsigned 3×5:
  - stimulus: `ld_in`, then `p_in`=0x000F, then `p_in`=0x0000 with `valid_in`;
  - next cycle: `res_out`=0x0000000F, z=0, s=0, ovf=0, `busy` back to 0.
- Signed −2×3 (`signd`=1):
  - stimulus: low 0xFFFA, high 0xFFFF;
  - `res_out`=0xFFFFFFFA, s=1, ovf=0 (with macro).
- Unsigned 0x0100×0x0100:
  - stimulus: low 0x0000, high 0x0001;
  - `res_out`=0x00010000, ovf=1 with macro, 0 without.
- Zero:
  - stimulus: low 0x0000, high 0x0000;
  - z=1, s=0.
- Back-pressure, `res_ready`=0, depth 2:
  - two products are stored, and `busy`=1 after the second `ld_in`;
  - a forced third `valid_in` is dropped and `ovr`=1;
  - releasing `res_ready` pops both in order.
- Reset asserted while in WAIT with one stored entry:
  - next cycle `res_valid`=0 and `busy`=0;
  - a following product behaves as the first scenario.

Source files
------------

// File: rtl/alu_mul_collect_pkg.sv
// Shared ALU definitions for the multiplier result collector: widths,
// in-flight FSM encoding and FIFO entry field sizes.
package alu_mul_collect_pkg;

    localparam int DATA_WL_DEF = 16;

    // One-hot in-flight tracking for the single-issue multiplier
    typedef enum logic [1:0] {
        S_IDLE = 2'b01,
        S_WAIT = 2'b10
    } inflight_e;

    localparam int Z_W   = 1;
    localparam int S_W   = 1;
    localparam int OVF_W = 1;

    function automatic int res_w(input int dwl);
        return 2 * dwl;
    endfunction

endpackage

// File: rtl/alu_mul_collect_if.sv
// Result-side handshake bus of the collector: assembled product, flags and
// valid/ready.
interface alu_mul_collect_if
    import alu_mul_collect_pkg::*;
#(
    parameter int DATA_WL = DATA_WL_DEF
);
    logic [2*DATA_WL-1:0] res_out;
    logic                 res_valid;
    logic                 res_ready;
    logic                 res_z;
    logic                 res_s;
    logic                 res_ovf;

    modport master (output res_out, res_valid, res_z, res_s, res_ovf, input res_ready);
    modport slave  (input res_out, res_valid, res_z, res_s, res_ovf, output res_ready);
endinterface

// File: rtl/alu_res_fifo.sv
// Parameterised synchronous FIFO; the caller must never push when full
// without popping in the same cycle.
module alu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    // Storage needs no reset: pointers and count define what is live
    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/alu_mul_collect.sv
// Reassembles the two-beat multiplier product, derives flags and queues
// results; define ALU_MUL_COLLECT_OVF_EN to store a per-entry overflow flag.
module alu_mul_collect
    import alu_mul_collect_pkg::*;
#(
    parameter int DATA_WL = DATA_WL_DEF,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_in,
    input  logic               signd,
    input  logic [DATA_WL-1:0] p_in,
    input  logic               valid_in,
    output logic               busy,
    output logic               ovr,
    alu_mul_collect_if.master  res_if
);
    localparam int RW = res_w(DATA_WL);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef ALU_MUL_COLLECT_OVF_EN
    localparam int EW = RW + Z_W + S_W + OVF_W;
`else
    localparam int EW = RW + Z_W + S_W;
`endif

    inflight_e          st_q, st_d;
    logic [DATA_WL-1:0] lo_q, lo_d;
    logic               ovr_q, ovr_d;
    logic [RW-1:0]      res;
    logic               z, s;
    logic [EW-1:0]      wdata, rdata;
    logic               push, pop, full, empty;
    logic [CW-1:0]      count;
    logic [CW:0]        credit;

    assign res = {p_in, lo_q};
    assign z   = (res == '0);
    assign s   = signd & p_in[DATA_WL-1];

`ifdef ALU_MUL_COLLECT_OVF_EN
    logic ovf;
    assign ovf   = signd ? (p_in != {DATA_WL{lo_q[DATA_WL-1]}}) : (p_in != '0);
    assign wdata = {res, z, s, ovf};
`else
    assign wdata = {res, z, s};
`endif

    // Credit counts the product in flight so a full FIFO is never overrun
    assign credit = {1'b0, count} + {{CW{1'b0}}, (st_q == S_WAIT)};
    assign busy   = (credit >= (CW+1)'(DEPTH));

    assign pop  = !empty && res_if.res_ready;
    assign push = valid_in && (!full || pop);

    always_comb begin
        st_d  = st_q;
        lo_d  = valid_in ? lo_q : p_in;
        ovr_d = ovr_q | (valid_in & full & ~pop);
        case (st_q)
            S_IDLE:  if (ld_in && !busy) st_d = S_WAIT;
            S_WAIT:  if (valid_in) st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= S_IDLE;
            lo_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            lo_q  <= lo_d;
            ovr_q <= ovr_d;
        end
    end

    alu_res_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Head fields are masked while empty so idle outputs read as zero
    assign ovr              = ovr_q;
    assign res_if.res_valid = !empty;
`ifdef ALU_MUL_COLLECT_OVF_EN
    assign res_if.res_out = empty ? '0 : rdata[EW-1 -: RW];
    assign res_if.res_z   = !empty & rdata[2];
    assign res_if.res_s   = !empty & rdata[1];
    assign res_if.res_ovf = !empty & rdata[0];
`else
    assign res_if.res_out = empty ? '0 : rdata[EW-1 -: RW];
    assign res_if.res_z   = !empty & rdata[1];
    assign res_if.res_s   = !empty & rdata[0];
    assign res_if.res_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_alu_mul_collect.sv
// Directed bench for alu_mul_collect: assembly, flags, back-pressure,
// overflow drop and mid-operation reset.
module tb_alu_mul_collect;
    logic        clk = 1'b0;
    logic        reset;
    logic        ld_in, signd, valid_in;
    logic [15:0] p_in;
    logic        busy, ovr;
    int          ntests = 0;
    int          nfail  = 0;

`ifdef ALU_MUL_COLLECT_OVF_EN
    localparam logic OVF_BIG = 1'b1;
`else
    localparam logic OVF_BIG = 1'b0;
`endif

    alu_mul_collect_if #(.DATA_WL(16)) rif ();

    alu_mul_collect #(.DATA_WL(16), .DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_in    (ld_in),
        .signd    (signd),
        .p_in     (p_in),
        .valid_in (valid_in),
        .busy     (busy),
        .ovr      (ovr),
        .res_if   (rif.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ld pulse, low beat, high beat with valid_in; results visible on return
    task automatic product(input logic [15:0] lo, input logic [15:0] hi, input logic sg);
        signd = sg;
        ld_in = 1'b1;
        tick();
        ld_in = 1'b0;
        p_in  = lo;
        tick();
        p_in     = hi;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        p_in     = 16'h0;
    endtask

    task automatic pop_one();
        rif.res_ready = 1'b1;
        tick();
        rif.res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ld_in = 1'b0; signd = 1'b0; valid_in = 1'b0;
        p_in = 16'h0; rif.res_ready = 1'b0;
        tick(); tick();
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_valid", 32'(rif.res_valid), 32'h0);
        chk("rst_out",   rif.res_out, 32'h0);
        chk("rst_z",     32'(rif.res_z), 32'h0);
        chk("rst_s",     32'(rif.res_s), 32'h0);
        chk("rst_ovf",   32'(rif.res_ovf), 32'h0);
        chk("rst_ovr",   32'(ovr), 32'h0);
        reset = 1'b0;
        tick();

        // unsigned 3x5
        product(16'h000F, 16'h0000, 1'b0);
        chk("u35_valid", 32'(rif.res_valid), 32'h1);
        chk("u35_out",   rif.res_out, 32'h0000000F);
        chk("u35_z",     32'(rif.res_z), 32'h0);
        chk("u35_s",     32'(rif.res_s), 32'h0);
        chk("u35_ovf",   32'(rif.res_ovf), 32'h0);
        chk("u35_busy",  32'(busy), 32'h0);
        pop_one();
        chk("u35_popped", 32'(rif.res_valid), 32'h0);

        // signed -2x3
        product(16'hFFFA, 16'hFFFF, 1'b1);
        chk("sgn_out", rif.res_out, 32'hFFFFFFFA);
        chk("sgn_s",   32'(rif.res_s), 32'h1);
        chk("sgn_ovf", 32'(rif.res_ovf), 32'h0);
        chk("sgn_z",   32'(rif.res_z), 32'h0);
        pop_one();

        // unsigned 0x0100 x 0x0100
        product(16'h0000, 16'h0001, 1'b0);
        chk("big_out", rif.res_out, 32'h00010000);
        chk("big_ovf", 32'(rif.res_ovf), 32'(OVF_BIG));
        chk("big_s",   32'(rif.res_s), 32'h0);
        pop_one();

        // zero, with res_ready held high: no bypass, entry shows next cycle
        rif.res_ready = 1'b1;
        signd = 1'b0;
        ld_in = 1'b1; tick();
        ld_in = 1'b0; p_in = 16'h0; tick();
        valid_in = 1'b1;
        chk("zero_nobypass", 32'(rif.res_valid), 32'h0);
        tick();
        valid_in = 1'b0;
        chk("zero_valid", 32'(rif.res_valid), 32'h1);
        chk("zero_z",     32'(rif.res_z), 32'h1);
        chk("zero_s",     32'(rif.res_s), 32'h0);
        tick();
        rif.res_ready = 1'b0;
        chk("zero_popped", 32'(rif.res_valid), 32'h0);

        // back-pressure: two stored, third dropped
        product(16'h0001, 16'h0000, 1'b0);
        chk("bp_busy1", 32'(busy), 32'h0);
        ld_in = 1'b1; tick();
        ld_in = 1'b0;
        chk("bp_busy_ld2", 32'(busy), 32'h1);
        p_in = 16'h0002; tick();
        p_in = 16'h0000; valid_in = 1'b1; tick();
        valid_in = 1'b0;
        chk("bp_busy_full", 32'(busy), 32'h1);
        chk("bp_ovr0",      32'(ovr), 32'h0);
        p_in = 16'h0003; tick();
        p_in = 16'h0000; valid_in = 1'b1; tick();
        valid_in = 1'b0;
        chk("bp_ovr1",   32'(ovr), 32'h1);
        chk("bp_stable", rif.res_out, 32'h00000001);
        rif.res_ready = 1'b1; tick();
        chk("bp_second", rif.res_out, 32'h00000002);
        chk("bp_valid2", 32'(rif.res_valid), 32'h1);
        tick();
        rif.res_ready = 1'b0;
        chk("bp_empty",  32'(rif.res_valid), 32'h0);
        chk("bp_busy0",  32'(busy), 32'h0);
        chk("bp_sticky", 32'(ovr), 32'h1);

        // reset while in WAIT with one stored entry
        product(16'h0005, 16'h0000, 1'b0);
        ld_in = 1'b1; tick();
        ld_in = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("rw_valid", 32'(rif.res_valid), 32'h0);
        chk("rw_busy",  32'(busy), 32'h0);
        chk("rw_ovr",   32'(ovr), 32'h0);
        product(16'h000F, 16'h0000, 1'b0);
        chk("rw_out",   rif.res_out, 32'h0000000F);
        chk("rw_valid2", 32'(rif.res_valid), 32'h1);
        chk("rw_busy2", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
